// File: rtl/ifft_pkg.sv
// Shared constants and state type for the 32-point IFFT twiddle sequencer.
package ifft_pkg;

   localparam int FFT_LOG2N    = 5;
   localparam int N_BFLY       = 16;
   localparam int STAGE_W      = 3;
   localparam int BFLY_W       = 4;
   localparam int TW_W_DFLT    = 7;
   localparam int MUL_LAT_DFLT = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

endpackage

// File: rtl/tw_index_gen.sv
// Twiddle exponent for a radix-2 DIF butterfly: k = (bfly mod 2^(LOG2N-1-stage)) << stage.
module tw_index_gen
   import ifft_pkg::*;
#(
   parameter int LOG2N = FFT_LOG2N,
   parameter int TW_W  = TW_W_DFLT
) (
   input  logic [STAGE_W-1:0] stage,
   input  logic [BFLY_W-1:0]  bfly,
   output logic [TW_W-1:0]    k
);

   logic [BFLY_W-1:0] mask_s;
   logic [BFLY_W-1:0] m_s;

   // The modulo by a power of two is a mask that shrinks by one bit per stage.
   always_comb begin
      mask_s = BFLY_W'((1 << (LOG2N - 1)) - 1) >> stage;
      m_s    = bfly & mask_s;
      k      = TW_W'(m_s) << stage;
   end

endmodule

// File: rtl/ifft_tw_sched.sv
// Issue sequencer for the shared IFFT complex multiplier; optional macro
// TW_TRIVIAL_BYPASS_EN adds a mul_bypass flag for W^0 butterflies.
module ifft_tw_sched
   import ifft_pkg::*;
#(
   parameter int LOG2N   = FFT_LOG2N,
   parameter int TW_W    = TW_W_DFLT,
   parameter int MUL_LAT = MUL_LAT_DFLT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stall,
   output logic               busy,
   output logic               mul_en,
   output logic [TW_W-1:0]    twsel,
   output logic [STAGE_W-1:0] stage,
   output logic [BFLY_W-1:0]  bfly,
   output logic               out_valid,
   output logic               out_last,
   output logic               done
`ifdef TW_TRIVIAL_BYPASS_EN
   ,
   output logic               mul_bypass
`endif
);

   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);
   localparam logic [BFLY_W-1:0]  LAST_BFLY  = BFLY_W'((1 << (LOG2N - 1)) - 1);

   sched_state_e       state_r;
   sched_state_e       state_nx;
   logic [STAGE_W-1:0] stage_nx;
   logic [BFLY_W-1:0]  bfly_nx;
   logic               issue_nx;
   logic               last_issue_s;
   logic [TW_W-1:0]    k_nx;
   logic [MUL_LAT-1:0] vld_pipe_r;
   logic [MUL_LAT-1:0] last_pipe_r;

   // The butterfly on the outputs right now is the final one of the frame.
   assign last_issue_s = mul_en && (stage == LAST_STAGE) && (bfly == LAST_BFLY);

   tw_index_gen #(
      .LOG2N (LOG2N),
      .TW_W  (TW_W)
   ) u_tw_index_gen (
      .stage (stage_nx),
      .bfly  (bfly_nx),
      .k     (k_nx)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next state and next issue position; a stalled position was already issued, so resume advances past it.
   always_comb begin
      state_nx = state_r;
      issue_nx = 1'b0;
      stage_nx = stage;
      bfly_nx  = bfly;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               issue_nx = 1'b1;
               stage_nx = {STAGE_W{1'b0}};
               bfly_nx  = {BFLY_W{1'b0}};
            end else begin
               state_nx = IDLE;
            end
         end
         RUN: begin
            if (last_issue_s) begin
               state_nx = DRAIN;
            end else if (stall) begin
               issue_nx = 1'b0;
            end else begin
               issue_nx = 1'b1;
               if (bfly == LAST_BFLY) begin
                  bfly_nx  = {BFLY_W{1'b0}};
                  stage_nx = stage + STAGE_W'(1);
               end else begin
                  bfly_nx  = bfly + BFLY_W'(1);
               end
            end
         end
         DRAIN: begin
            if (last_pipe_r[MUL_LAT-1]) begin
               state_nx = IDLE;
            end else begin
               state_nx = DRAIN;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Issue outputs and the multiplier valid/last shadow pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy        <= 1'b0;
         mul_en      <= 1'b0;
         twsel       <= {TW_W{1'b0}};
         stage       <= {STAGE_W{1'b0}};
         bfly        <= {BFLY_W{1'b0}};
         vld_pipe_r  <= {MUL_LAT{1'b0}};
         last_pipe_r <= {MUL_LAT{1'b0}};
      end else begin
         busy           <= (state_nx != IDLE);
         mul_en         <= issue_nx;
         twsel          <= k_nx;
         stage          <= stage_nx;
         bfly           <= bfly_nx;
         vld_pipe_r[0]  <= mul_en;
         last_pipe_r[0] <= last_issue_s;
         for (int i = 1; i < MUL_LAT; i++) begin
            vld_pipe_r[i]  <= vld_pipe_r[i-1];
            last_pipe_r[i] <= last_pipe_r[i-1];
         end
      end
   end

   assign out_valid = vld_pipe_r[MUL_LAT-1];
   assign out_last  = last_pipe_r[MUL_LAT-1];
   assign done      = last_pipe_r[MUL_LAT-1];

`ifdef TW_TRIVIAL_BYPASS_EN
   // W^0 needs no multiply; flag it alongside the issue so the datapath can route around commul.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_bypass <= 1'b0;
      end else begin
         mul_bypass <= issue_nx && (k_nx == {TW_W{1'b0}});
      end
   end
`endif

endmodule
